// File: rtl/mul32_column_collector.sv
// mul32_column_collector
//   Receiving end of the mul32 byte-column datapath. Accepts the seven column
//   results (carry byte + 16-bit sum) of one 32x32 multiply in any order,
//   shifts each by 8*col, accumulates the 64-bit product and hands it
//   downstream over valid/ready.
//
//   Optional feature macro: MUL32_COLLECT_ERR_EN
//     defined   : out_err port exists; illegal (col 7) and duplicate columns are
//                 dropped and flag a sticky per-frame error.
//     undefined : col 7 is accepted and ignored; duplicates are added again.
//
// Ports
//   clk, rst      clock (rising edge), synchronous active-high reset
//   in_valid      column result present
//   in_ready      block can accept a column this cycle (registered)
//   in_col        column index 0..6
//   in_carry      column carry byte
//   in_sum        column sum
//   out_valid     product ready (registered)
//   out_ready     downstream takes the product
//   out_product   assembled product, 0 while out_valid=0 (registered)
//   out_err       sticky per-frame error (MUL32_COLLECT_ERR_EN only)

module mul32_column_collector #(
    parameter int unsigned UUID = 0,
    parameter              NAME = "",
    parameter int unsigned NCOL = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_col,
    input  logic [7:0]  in_carry,
    input  logic [15:0] in_sum,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_product
`ifdef MUL32_COLLECT_ERR_EN
    ,
    output logic        out_err
`endif
);

    localparam int unsigned PROD_W = 64;
    localparam int unsigned MASK_W = 7;
    localparam logic [MASK_W-1:0] MASK_FULL = MASK_W'((1 << NCOL) - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC,
        ST_DONE
    } state_t;

    state_t              state_q, state_n;
    logic [PROD_W-1:0]   acc_q, acc_n;
    logic [MASK_W-1:0]   mask_q, mask_n;

    logic                accept;
    logic                col_legal;
    logic [MASK_W-1:0]   col_sel;
    logic                take;
    logic [PROD_W-1:0]   addend;

    // Identification parameters carry no logic; fold them into a sink.
    logic unused_cfg;
    assign unused_cfg = ^{UUID, NAME};

    // Column decode: col 7 selects no mask bit and is never added.
    assign accept    = in_valid & in_ready;
    assign col_legal = (in_col != 3'd7);
    assign col_sel   = MASK_W'(7'd1 << in_col);
    assign addend    = {40'd0, in_carry, in_sum} << {in_col, 3'b000};

`ifdef MUL32_COLLECT_ERR_EN
    logic err_q, err_n;
    logic dup;

    // Duplicates and illegal columns are dropped and flagged.
    assign dup  = |(mask_q & col_sel);
    assign take = accept & col_legal & ~dup;
`else
    // Duplicates are summed again; col 7 is silently ignored.
    assign take = accept & col_legal;
`endif

    // Next-state and datapath update.
    always_comb begin
        state_n = state_q;
        acc_n   = acc_q;
        mask_n  = mask_q;
`ifdef MUL32_COLLECT_ERR_EN
        err_n   = err_q;
`endif
        case (state_q)
            ST_IDLE, ST_ACC: begin
                if (take) begin
                    acc_n  = acc_q + addend;
                    mask_n = mask_q | col_sel;
                end
`ifdef MUL32_COLLECT_ERR_EN
                if (accept && !take) begin
                    err_n = 1'b1;
                end
`endif
                if (state_q == ST_IDLE) begin
                    if (accept) begin
                        state_n = ST_ACC;
                    end
                end else if (mask_q == MASK_FULL) begin
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                // out_valid is always high in DONE, so out_ready alone is the handoff.
                if (out_ready) begin
                    state_n = ST_IDLE;
                    acc_n   = '0;
                    mask_n  = '0;
`ifdef MUL32_COLLECT_ERR_EN
                    err_n   = 1'b0;
`endif
                end
            end
            default: begin
                state_n = ST_IDLE;
                acc_n   = '0;
                mask_n  = '0;
            end
        endcase
    end

    // State and registered outputs; outputs are derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            mask_q      <= '0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            out_product <= '0;
        end else begin
            state_q     <= state_n;
            acc_q       <= acc_n;
            mask_q      <= mask_n;
            in_ready    <= (state_n != ST_DONE);
            out_valid   <= (state_n == ST_DONE);
            out_product <= (state_n == ST_DONE) ? acc_n : '0;
        end
    end

`ifdef MUL32_COLLECT_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_n;
        end
    end

    assign out_err = err_q;
`endif

endmodule

// File: tb/tb_mul32_column_collector.sv
// Directed bench for mul32_column_collector: in-order and shuffled frames,
// carry ripple, output backpressure, mid-frame reset and error handling.

module tb_mul32_column_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_col;
    logic [7:0]  in_carry;
    logic [15:0] in_sum;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_product;
`ifdef MUL32_COLLECT_ERR_EN
    logic        out_err;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [63:0] T1_PROD = 64'h0001_0101_0101_0101;
    localparam logic [63:0] T2_PROD = 64'h0000_0000_0100_00FF;

    always #5 clk = ~clk;

    mul32_column_collector #(.UUID(0), .NAME("dut"), .NCOL(7)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_col     (in_col),
        .in_carry   (in_carry),
        .in_sum     (in_sum),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_product(out_product)
`ifdef MUL32_COLLECT_ERR_EN
        ,
        .out_err    (out_err)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one column and hold it until accepted; returns 1 ns after the accepting edge.
    task automatic send_col(input logic [2:0] c, input logic [7:0] ca, input logic [15:0] s);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_col   = c;
        in_carry = ca;
        in_sum   = s;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_col   = 3'($urandom_range(0, 7));
        in_carry = 8'($urandom);
        in_sum   = 16'($urandom);
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) check(tag, 64'(out_valid), 64'd1);
    endtask

    task automatic send_t1_inorder();
        for (int i = 0; i < 7; i++) send_col(3'(i), 8'h00, 16'h0001);
    endtask

    initial begin
        int order [7] = '{6, 3, 0, 5, 1, 4, 2};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_col    = 3'd0;
        in_carry  = 8'd0;
        in_sum    = 16'd0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid",   64'(out_valid), 64'd0);
        check("rst_out_product", out_product,    64'd0);
        check("rst_in_ready",    64'(in_ready),  64'd0);
`ifdef MUL32_COLLECT_ERR_EN
        check("rst_out_err",     64'(out_err),   64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // T1: in-order frame, one-cycle output
        send_t1_inorder();
        check("t1_lat_early", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check("t1_valid",   64'(out_valid), 64'd1);
        check("t1_product", out_product,    T1_PROD);
        check("t1_in_ready_done", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        check("t1_valid_drop",   64'(out_valid), 64'd0);
        check("t1_product_zero", out_product,    64'd0);
        check("t1_in_ready_back", 64'(in_ready), 64'd1);

        // T2: carry ripple across column boundary
        send_col(3'd0, 8'hFF, 16'hFFFF);
        send_col(3'd1, 8'h00, 16'h0001);
        for (int i = 2; i < 7; i++) send_col(3'(i), 8'h00, 16'h0000);
        wait_valid("t2_valid_timeout");
        check("t2_product", out_product, T2_PROD);
        @(posedge clk); #1;

        // T3: shuffled order, latency after last column
        for (int i = 0; i < 7; i++) send_col(3'(order[i]), 8'h00, 16'h0001);
        check("t3_lat_early", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check("t3_valid",   64'(out_valid), 64'd1);
        check("t3_product", out_product,    T1_PROD);
        @(posedge clk); #1;

        // T4: output backpressure
        out_ready = 1'b0;
        send_col(3'd1, 8'h00, 16'h0001);
        send_col(3'd0, 8'hFF, 16'hFFFF);
        for (int i = 2; i < 7; i++) send_col(3'(i), 8'h00, 16'h0000);
        wait_valid("t4_valid_timeout");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_hold_in_ready", 64'(in_ready),  64'd0);
            check("t4_hold_valid",    64'(out_valid), 64'd1);
            check("t4_hold_product",  out_product,    T2_PROD);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("t4_release_valid",    64'(out_valid), 64'd0);
        check("t4_release_in_ready", 64'(in_ready),  64'd1);

        // T5: reset discards a partial frame
        for (int i = 0; i < 3; i++) send_col(3'(i), 8'hFF, 16'hFFFF);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("t5_rst_in_ready",  64'(in_ready),  64'd0);
        check("t5_rst_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        send_t1_inorder();
        wait_valid("t5_valid_timeout");
        check("t5_product", out_product, T1_PROD);
        @(posedge clk); #1;

        // T6: duplicate and illegal column
        send_col(3'd2, 8'h00, 16'h0005);
        send_col(3'd2, 8'h00, 16'h0005);
`ifdef MUL32_COLLECT_ERR_EN
        check("t6_err_dup", 64'(out_err), 64'd1);
`endif
        send_col(3'd7, 8'hFF, 16'hFFFF);
        send_col(3'd0, 8'h00, 16'h0000);
        send_col(3'd1, 8'h00, 16'h0000);
        for (int i = 3; i < 7; i++) send_col(3'(i), 8'h00, 16'h0000);
        wait_valid("t6_valid_timeout");
`ifdef MUL32_COLLECT_ERR_EN
        check("t6_product", out_product, 64'h0000_0000_0005_0000);
        check("t6_err_done", 64'(out_err), 64'd1);
        @(posedge clk); #1;
        check("t6_err_clear", 64'(out_err), 64'd0);
`else
        check("t6_product", out_product, 64'h0000_0000_000A_0000);
        @(posedge clk); #1;
`endif
        check("t6_valid_drop", 64'(out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
